vector_mem_stage: RTL
=====================

Name: vector_mem_stage

Overview:
- MEM stage of the interpolation ASIP pipeline. Holds the EX/MEM pipeline register and performs scalar and vector loads/stores over a 32-bit synchronous data-memory port.
- Vector accesses are split into LANES sequential 32-bit beats; the upstream pipeline is stalled until the access completes.
- Drives rd_mem, write_enable_mem, wb_sel and result_mem directly into the forwarding unit and MEM/WB register.

Parameters:
- LANES, 8, 32-bit lanes per vector register.
- XLEN, 32, scalar/lane width in bits; VLEN = LANES*XLEN (256).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EX stage holds a valid instruction
- req_op  in  2  mem_op_t: NONE=0, LOAD=1, STORE=2
- req_vector  in  1  1 = vector (LANES beats), 0 = scalar (1 beat, lane 0)
- req_rd  in  5  destination register
- req_we  in  1  instruction writes a register
- req_addr  in  ADDR_W  byte address
- req_wdata  in  VLEN  store data; scalar uses [31:0]
- req_alu  in  VLEN  EX result for non-load ops
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  XLEN  write data
- mem_rdata  in  XLEN  read data, valid the cycle after mem_re
- mem_stall  out  1  freeze IF/ID/EX and hold req_*
- rd_mem  out  5  MEM-stage destination
- write_enable_mem  out  1  MEM-stage register write
- wb_sel  out  1  1 = result from memory (load), 0 = ALU
- result_mem  out  VLEN  MEM-stage result
- misalign_err  out  1  see Optional Feature

Behaviour:
- Reset (async): all outputs and registers go to 0; state = IDLE; any in-flight access is aborted and no further strobes are issued.
- Capture: on each rising edge with mem_stall=0, the EX/MEM register loads req_*.
  - req_valid=0 captures a bubble: write_enable_mem=0, op NONE.
  - result_mem <= req_alu for non-loads.
  - rd_mem and write_enable_mem <= req_rd and req_we.
  - wb_sel <= (req_op==LOAD).
- Beat address: beat i uses req_addr + 4*i, wrapping modulo 2^ADDR_W. Lane i maps to bits [32i+31:32i].
- FSM states: IDLE, LOAD, LOAD_TAIL, STORE.
- IDLE:
  - Captured NONE op: no strobes, no stall.
  - Captured scalar STORE: single-cycle mem_we, no stall.
  - Captured LOAD: issue beat 0 in the capture's first cycle, go to LOAD (or LOAD_TAIL if scalar).
  - Captured vector STORE: issue beat 0, go to STORE.
- LOAD:
  - Each cycle, issue beat cnt and store mem_rdata from beat cnt-1 into its lane.
  - After the beat with cnt=LANES-1 is issued, go to LOAD_TAIL.
- LOAD_TAIL: capture the final lane, deassert mem_stall, return to IDLE.
- STORE: issue beats 1..LANES-1 with mem_wdata = lane cnt; return to IDLE after the last beat.
- Stall timing:
  - Vector load: occupancy LANES+1 cycles, mem_stall high for the first LANES.
  - Scalar load: occupancy 2 cycles, stall 1. Scalar load writes lane 0; lanes 1..7 are zero.
  - Vector store: occupancy LANES cycles, stall LANES-1.
  - Scalar store: occupancy 1 cycle, no stall.
- mem_stall is combinational from state. result_mem is valid only when mem_stall=0. rd_mem, write_enable_mem and wb_sel are stable throughout occupancy, so the forwarding unit can detect the load hazard.
- mem_re and mem_we are never both 1. Strobes appear only in LOAD/STORE issue cycles.
- Back-to-back memory ops: the next op is captured on the edge where mem_stall=0, with no idle cycle in between.

Optional Feature:
- Macro: VMEM_MISALIGN_CHECK_EN.
- With the macro: if a captured LOAD/STORE has addr[1:0]!=0, misalign_err is high for the stage occupancy (1 cycle). No strobes are issued, no stall occurs, and write_enable_mem is forced to 0.
- Without the macro: misalign_err is tied 0 and addr[1:0] is forced to 00.

Decomposition:
- Package vmem_pkg holds: mem_op_t enum, state_t enum, LANES/XLEN/VLEN constants, and a lane-index width function.
- One sub-module, vmem_beat_sequencer, contains the FSM plus beat counter and produces state, cnt, strobes and mem_stall.
- The top level holds the EX/MEM register, address adder and lane assembly.

Test Plan:
- ALU op, req_alu=256'h1234567890ABCDEF, rd=3, we=1 -> next cycle result_mem=256'h1234567890ABCDEF, wb_sel=0, mem_stall never high.
- Vector load, addr=0x100, memory word k = 0xA000+k -> mem_re on addresses 0x100..0x11C; mem_stall high 8 cycles; then result_mem lanes 0..7 = 0xA040..0xA047, wb_sel=1.
- Vector store, addr=0x200, wdata lanes = 0..7 -> 8 consecutive mem_we with mem_wdata 0..7 at 0x200..0x21C; mem_stall high 7 cycles.
- Scalar load at 0xFFFFFFFC followed immediately by vector load at 0xFFFFFFF8 -> 1-cycle stall then 8-cycle stall; beat addresses wrap 0xFFFFFFF8, 0xFFFFFFFC, 0x0, …; no gap between ops.
- Assert rst during cycle 4 of a vector load -> all outputs 0 immediately, no further strobes; after release a new scalar store issues normally.
- With VMEM_MISALIGN_CHECK_EN, load at 0x102 -> misalign_err=1 for 1 cycle, no mem_re, write_enable_mem=0.

Source files
------------

// File: rtl/vmem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vmem_pkg                                                               |
// | Shared types and constants for the vector MEM stage.                   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package vmem_pkg;

    localparam int VMEM_LANES = 8;
    localparam int VMEM_XLEN  = 32;
    localparam int VMEM_VLEN  = VMEM_LANES * VMEM_XLEN;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_LOAD_TAIL = 2'd2,
        ST_STORE     = 2'd3
    } state_t;

    // Bits needed to index a lane; at least 1 so single-lane builds still elaborate.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vmem_beat_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vmem_beat_sequencer                                                    |
// | Beat FSM and counter: issues memory strobes and the upstream stall.    |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module vmem_beat_sequencer
    import vmem_pkg::*;
#(
    parameter int LANES = VMEM_LANES,
    parameter int CW    = lane_idx_w(LANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  mem_op_t       i_op,
    input  logic          i_vector,
    output state_t        o_state,
    output logic [CW-1:0] o_cnt,
    output logic          o_mem_re,
    output logic          o_mem_we,
    output logic          o_mem_stall
);

    localparam logic [CW-1:0] c_last_beat = CW'(LANES - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_next_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // The counter is zero outside LOAD/STORE, so it doubles as the beat index.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_stall  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_cnt = '0;
                if (i_op == OP_LOAD) begin
                    o_mem_re    = 1'b1;
                    o_mem_stall = 1'b1;
                    if (i_vector && (LANES > 1)) begin
                        w_next_state = ST_LOAD;
                        w_next_cnt   = CW'(1);
                    end else begin
                        w_next_state = ST_LOAD_TAIL;
                    end
                end else if (i_op == OP_STORE) begin
                    o_mem_we = 1'b1;
                    if (i_vector && (LANES > 1)) begin
                        o_mem_stall  = 1'b1;
                        w_next_state = ST_STORE;
                        w_next_cnt   = CW'(1);
                    end
                end
            end
            ST_LOAD: begin
                o_mem_re    = 1'b1;
                o_mem_stall = 1'b1;
                if (r_cnt == c_last_beat) begin
                    w_next_state = ST_LOAD_TAIL;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            ST_LOAD_TAIL: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
            ST_STORE: begin
                o_mem_we = 1'b1;
                if (r_cnt == c_last_beat) begin
                    w_next_state = ST_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    o_mem_stall = 1'b1;
                    w_next_cnt  = r_cnt + CW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: rtl/vector_mem_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vector_mem_stage                                                       |
// | EX/MEM register plus scalar/vector load-store over a 32-bit port.      |
// | Optional macro VMEM_MISALIGN_CHECK_EN enables misaligned-access trap.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module vector_mem_stage
    import vmem_pkg::*;
#(
    parameter  int LANES  = VMEM_LANES,
    parameter  int XLEN   = VMEM_XLEN,
    parameter  int ADDR_W = 32,
    localparam int VLEN   = LANES * XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic              req_vector,
    input  logic [4:0]        req_rd,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [VLEN-1:0]   req_wdata,
    input  logic [VLEN-1:0]   req_alu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              mem_stall,
    output logic [4:0]        rd_mem,
    output logic              write_enable_mem,
    output logic              wb_sel,
    output logic [VLEN-1:0]   result_mem,
    output logic              misalign_err
);

    localparam int            CW          = lane_idx_w(LANES);
    localparam logic [CW-1:0] c_tail_lane = CW'(LANES - 1);

    mem_op_t           w_req_op;
    logic              w_req_load;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_cap_addr;

    mem_op_t           r_op;
    logic              r_vector;
    logic [ADDR_W-1:0] r_addr;
    logic [VLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_lane [LANES];
    logic [4:0]        r_rd;
    logic              r_we;
    logic              r_wb_sel;
    logic              r_misalign;

    state_t            w_state;
    logic [CW-1:0]     w_cnt;
    logic              w_stall;
    logic [CW-1:0]     w_tail_lane;
    logic [XLEN-1:0]   w_wlane [LANES];

    assign w_req_op   = mem_op_t'(req_op);
    assign w_req_load = req_valid && (w_req_op == OP_LOAD);

`ifdef VMEM_MISALIGN_CHECK_EN
    assign w_misalign = req_valid && ((w_req_op == OP_LOAD) || (w_req_op == OP_STORE))
                        && (req_addr[1:0] != 2'b00);
    assign w_cap_addr = req_addr;
`else
    assign w_misalign = 1'b0;
    assign w_cap_addr = req_addr & ~ADDR_W'(3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= OP_NONE;
            r_vector   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_wb_sel   <= 1'b0;
            r_misalign <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
            end
        end else if (!w_stall) begin
            // A misaligned access becomes a bubble so no strobe ever leaves the stage.
            r_op       <= (req_valid && !w_misalign) ? w_req_op : OP_NONE;
            r_vector   <= req_vector;
            r_addr     <= w_cap_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
            r_we       <= req_valid && req_we && !w_misalign;
            r_wb_sel   <= w_req_load;
            r_misalign <= w_misalign;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= w_req_load ? '0 : req_alu[i*XLEN +: XLEN];
            end
        end else if (w_state == ST_LOAD) begin
            // Read data lags the strobe by one cycle, so it belongs to the previous beat.
            r_lane[w_cnt - CW'(1)] <= mem_rdata;
        end
    end

    vmem_beat_sequencer #(
        .LANES (LANES),
        .CW    (CW)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .i_op        (r_op),
        .i_vector    (r_vector),
        .o_state     (w_state),
        .o_cnt       (w_cnt),
        .o_mem_re    (mem_re),
        .o_mem_we    (mem_we),
        .o_mem_stall (w_stall)
    );

    assign w_tail_lane = r_vector ? c_tail_lane : '0;

    // The last lane is merged straight from the port so the result is complete in LOAD_TAIL.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_wlane[g]                 = r_wdata[g*XLEN +: XLEN];
        assign result_mem[g*XLEN +: XLEN] =
            ((w_state == ST_LOAD_TAIL) && (w_tail_lane == CW'(g))) ? mem_rdata : r_lane[g];
    end

    assign mem_addr         = r_addr + (ADDR_W'(w_cnt) << 2);
    assign mem_wdata        = w_wlane[w_cnt];
    assign mem_stall        = w_stall;
    assign rd_mem           = r_rd;
    assign write_enable_mem = r_we;
    assign wb_sel           = r_wb_sel;
    assign misalign_err     = r_misalign;

endmodule
`default_nettype wire
